win_buf_reader: RTL and testbench
=================================

Name: win_buf_reader

Overview:
- Sits directly downstream of the window-request generator. Consumes its req_valid / Loc_X / Loc_Y / new_block / read_finish stream and returns ready.
- Turns each accepted window coordinate into a read of one of two ping-pong on-chip image buffers.
- Drives the buffer-select / write-strobe pair that loads the output FIFO, aligned to the buffer read latency.
- Tracks which bank is loaded, and releases a bank back to the loader once its block has been fully read.

Parameters:
ADDR_W, 12, buffer word-address width (per bank)
RD_LAT, 2, buffer read latency in clk cycles (from buf_rd_en to valid data)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  window request valid from the request generator
ready  out  1  request accepted this cycle when req_valid && ready
loc_x  in  16  window column index (row number within buffer)
loc_y  in  16  window row offset (word within row)
new_block  in  1  qualifies the first request of a block (status only)
read_finish  in  1  qualifies the last request of a block
row_stride  in  16  words per buffer row, static while not IDLE
fifo_amfull  in  1  output FIFO almost-full (prog_full)
bank_fill_done  in  2  one-cycle pulse per bank: loader finished filling bank i
bank_release  out  2  one-cycle pulse per bank: bank i fully consumed
buf_rd_en  out  1  buffer read enable
buf_addr  out  ADDR_W  buffer read address
use_select  out  1  current bank (0 = buffer0, 1 = buffer1)
use_read  out  1  FIFO write strobe, buf_rd_en delayed RD_LAT cycles
blk_cnt  out  16  blocks completed since reset (wraps)
ovf_err  out  1  sticky: fill_done on an already-full bank

Behaviour:
- Reset values: all outputs 0; state IDLE; cur_bank=0; bank_full=2'b00; pipeline shift register cleared.
- Reset mid-operation aborts everything. In-flight use_read pulses are dropped. No bank_release is emitted.

bank_full[i] tracking:
- Set by bank_fill_done[i].
- Cleared in the same cycle that bank_release[i] pulses.
- If set and clear hit the same bank in the same cycle, the set wins.
- A fill_done on a bank already full sets ovf_err. ovf_err clears only on reset.

State machine:
- IDLE: ready=0. Go to RUN when bank_full[cur_bank]=1.
- RUN: ready = !fifo_amfull (combinational).
  - On each accept: buf_rd_en=1 in that same cycle; buf_addr = (loc_x*row_stride + loc_y) using a 32-bit product, truncated to the low ADDR_W bits; use_select = cur_bank.
  - Accept with read_finish=1: go to DRAIN. ready is 0 from the next cycle.
  - fifo_amfull rising while in RUN: stalls only new accepts. Outstanding reads still complete.
- DRAIN: ready=0. Wait RD_LAT cycles for the last data to be written (use_read of the last read has asserted). Then, in the exit cycle:
  - pulse bank_release[cur_bank];
  - toggle cur_bank;
  - increment blk_cnt;
  - go to IDLE.
- buf_rd_en and buf_addr are registered only if RD_LAT accounts for it. Decided: combinational from the accept, so the read is issued in the accept cycle.

Output alignment:
- use_read(t) = buf_rd_en(t-RD_LAT), via a shift register.
- use_select is held stable from the first read of a block until the DRAIN exit. The FIFO mux samples use_select delayed by two cycles, so it sees a stable value.
- new_block is not required for sequencing. An accept with new_block=1 outside the first request of a block is ignored.
- req_valid while IDLE or DRAIN is not accepted. The producer holds its request (valid/ready protocol).

Decomposition:
- Shared package: ADDR_W default, RD_LAT default, state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2).
- One natural sub-module: win_bank_tracker. It holds the bank_full/ovf_err set-clear logic for both banks and is instantiated once.
- Address multiply, FSM and the latency shift register stay in the top.

Test Plan:
- Bank 0 fill_done, row_stride=8, requests (x,y)=(0,0),(0,1),(1,0),(1,1)+read_finish, ready held 1 → buf_addr 0,1,8,9; use_select=0; use_read pulses exactly 2 cycles after each buf_rd_en; bank_release=2'b01 two cycles after last accept; blk_cnt=1.
- Second block with only bank 1 filled after the first release → IDLE until fill_done[1]; then use_select=1 for the whole block; release=2'b10; cur_bank returns to 0.
- fifo_amfull=1 for 5 cycles mid-block with req_valid held → ready=0, no buf_rd_en for those 5 cycles, no request lost or duplicated; total use_read count equals the accept count.
- fill_done[0] again while bank 0 still full → ovf_err=1 and stays 1. Fill_done[0] coincident with bank_release[0] → bank_full[0] remains 1, next block starts immediately.
- loc_x=300, loc_y=5, row_stride=16 → product 4805, buf_addr=4805 mod 4096=709.
- reset asserted during DRAIN → all outputs 0 asynchronously; no bank_release pulse; after deassertion stays IDLE until a fresh fill_done.

Source files
------------

// File: rtl/win_buf_reader_pkg.sv
// Shared definitions for the window buffer reader: default geometry,
// FSM state encoding and a small bank-decode helper.
package win_buf_reader_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int RD_LAT_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // One-hot pulse vector for a bank index.
    function automatic logic [1:0] bank_onehot(input logic bank);
        return bank ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/win_buf_reader_bank_tracker.sv
// Full/empty tracking for the two ping-pong image buffers.
// A fill that lands on a bank in the same cycle as its release keeps the bank
// full, because the loader has already refilled it.
module win_bank_tracker (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_fill_done,
    input  logic [1:0] i_release,
    output logic [1:0] o_bank_full,
    output logic       o_ovf_err
);

    logic [1:0] r_bank_full;
    logic       r_ovf_err;

    // Set on fill, clear on release (set wins), sticky overflow on refill of a full bank.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bank_full <= 2'b00;
            r_ovf_err   <= 1'b0;
        end else begin
            r_bank_full <= (r_bank_full & ~i_release) | i_fill_done;
            if (|(i_fill_done & r_bank_full)) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    assign o_bank_full = r_bank_full;
    assign o_ovf_err   = r_ovf_err;

endmodule

// File: rtl/win_buf_reader.sv
// Window buffer reader: converts accepted (loc_x, loc_y) window requests into
// reads of the current ping-pong bank, strobes the output FIFO RD_LAT cycles
// later, and hands each bank back to the loader once its block is consumed.
module win_buf_reader
    import win_buf_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_ready,
    input  logic [15:0]       i_loc_x,
    input  logic [15:0]       i_loc_y,
    input  logic              i_new_block,
    input  logic              i_read_finish,
    input  logic [15:0]       i_row_stride,
    input  logic              i_fifo_amfull,
    input  logic [1:0]        i_bank_fill_done,
    output logic [1:0]        o_bank_release,
    output logic              o_buf_rd_en,
    output logic [ADDR_W-1:0] o_buf_addr,
    output logic              o_use_select,
    output logic              o_use_read,
    output logic [15:0]       o_blk_cnt,
    output logic              o_ovf_err
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(RD_LAT - 1);

    state_t            r_state;
    logic              r_cur_bank;
    logic [15:0]       r_blk_cnt;
    logic [CNT_W-1:0]  r_drain_cnt;
    logic [RD_LAT-1:0] r_rd_pipe;

    logic        w_accept;
    logic        w_drain_exit;
    logic [31:0] w_prod;
    logic [1:0]  w_bank_full;
    logic        w_unused_bits;

    win_bank_tracker u_bank_tracker (
        .i_clk       (i_clk),
        .i_rst       (i_reset),
        .i_fill_done (i_bank_fill_done),
        .i_release   (o_bank_release),
        .o_bank_full (w_bank_full),
        .o_ovf_err   (o_ovf_err)
    );

    // The read is issued in the accept cycle, so RD_LAT counts from here.
    assign o_ready      = (r_state == ST_RUN) && !i_fifo_amfull;
    assign w_accept     = o_ready && i_req_valid;
    assign w_prod       = ({16'd0, i_loc_x} * {16'd0, i_row_stride}) + {16'd0, i_loc_y};
    assign o_buf_rd_en  = w_accept;
    assign o_buf_addr   = w_accept ? w_prod[ADDR_W-1:0] : '0;
    assign w_drain_exit = (r_state == ST_DRAIN) && (r_drain_cnt == '0);
    assign o_bank_release = w_drain_exit ? bank_onehot(r_cur_bank) : 2'b00;
    assign o_use_select = r_cur_bank;
    assign o_use_read   = r_rd_pipe[RD_LAT-1];
    assign o_blk_cnt    = r_blk_cnt;

    // new_block is status only; high product bits fall outside the bank.
    assign w_unused_bits = ^{i_new_block, w_prod[31:ADDR_W]};

    // Block sequencing: wait for a full bank, read it, drain the read pipe, release.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cur_bank  <= 1'b0;
            r_blk_cnt   <= 16'd0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_bank_full[r_cur_bank]) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_accept && i_read_finish) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_state    <= ST_IDLE;
                        r_cur_bank <= ~r_cur_bank;
                        r_blk_cnt  <= r_blk_cnt + 16'd1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Delay line aligning the FIFO write strobe with buffer read data.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_pipe <= '0;
        end else begin
            r_rd_pipe[0] <= w_accept;
            for (int i = 1; i < RD_LAT; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_win_buf_reader.sv
// Self-checking bench for win_buf_reader: table-driven address vectors plus
// hand sequences for stall, overflow, coincident fill/release and reset.
module tb_win_buf_reader;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, ready;
    logic [15:0] loc_x, loc_y, row_stride;
    logic        new_block, read_finish, fifo_amfull;
    logic [1:0]  bank_fill_done, bank_release;
    logic        buf_rd_en, use_select, use_read, ovf_err;
    logic [11:0] buf_addr;
    logic [15:0] blk_cnt;

    win_buf_reader #(.ADDR_W(12), .RD_LAT(RD_LAT)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_req_valid      (req_valid),
        .o_ready          (ready),
        .i_loc_x          (loc_x),
        .i_loc_y          (loc_y),
        .i_new_block      (new_block),
        .i_read_finish    (read_finish),
        .i_row_stride     (row_stride),
        .i_fifo_amfull    (fifo_amfull),
        .i_bank_fill_done (bank_fill_done),
        .o_bank_release   (bank_release),
        .o_buf_rd_en      (buf_rd_en),
        .o_buf_addr       (buf_addr),
        .o_use_select     (use_select),
        .o_use_read       (use_read),
        .o_blk_cnt        (blk_cnt),
        .o_ovf_err        (ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] addr;
        logic        sel;
    } exp_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        fin;
        logic [11:0] addr;
        logic        sel;
    } vec_t;

    int   n_chk = 0, n_err = 0;
    int   cyc = 0;
    int   rd_cnt = 0, ur_cnt = 0, rel_cnt = 0, acc_cnt = 0;
    int   last_acc_cyc = 0;
    exp_t sb[$];
    int   pend[$];
    exp_t mon_e;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: reads pop expected address/bank, strobes pop expected cycle.
    always @(negedge clk) begin
        if (buf_rd_en) begin
            rd_cnt++;
            pend.push_back(cyc + RD_LAT);
            chk("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("buf_addr", buf_addr, mon_e.addr);
                chk("use_select", use_select, mon_e.sel);
            end
        end
        if (use_read) begin
            ur_cnt++;
            chk("use_read_pending", pend.size() > 0, 1);
            if (pend.size() > 0) chk("use_read_cycle", cyc, pend.pop_front());
        end
        if (bank_release != 2'b00) rel_cnt++;
    end

    task automatic present(input logic [15:0] x, input logic [15:0] y, input logic fin,
                           input logic [11:0] a, input logic s);
        loc_x = x; loc_y = y; read_finish = fin; req_valid = 1'b1;
        sb.push_back('{addr: a, sel: s});
    endtask

    task automatic wait_accept();
        bit got = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (ready) begin
                got = 1;
                acc_cnt++;
                last_acc_cyc = cyc;
            end
        end
        chk("accept_in_time", got, 1);
        @(posedge clk); #1;
        req_valid = 1'b0; read_finish = 1'b0; new_block = 1'b0;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic fin,
                        input logic [11:0] a, input logic s);
        present(x, y, fin, a, s);
        wait_accept();
    endtask

    task automatic fill(input logic [1:0] b);
        bank_fill_done = b;
        @(posedge clk); #1;
        bank_fill_done = 2'b00;
    endtask

    task automatic idle_cycles(input int n, input string nm);
        int rd0 = rd_cnt;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(nm, ready, 0);
        end
        chk({nm, "_no_read"}, rd_cnt - rd0, 0);
    endtask

    task automatic expect_release(input logic [1:0] b, input logic [15:0] blk, input logic sel_after);
        bit got = 0;
        logic [1:0] v = 2'b00;
        int c = 0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            if (bank_release != 2'b00) begin
                got = 1; v = bank_release; c = cyc;
            end
        end
        chk("release_seen", got, 1);
        chk("release_bank", v, b);
        chk("release_cycle", c, last_acc_cyc + RD_LAT);
        @(posedge clk); #1;
        chk("blk_cnt", blk_cnt, blk);
        chk("use_select_after", use_select, sel_after);
    endtask

    task automatic check_zero_outputs(input string nm);
        chk({nm, "_ready"}, ready, 0);
        chk({nm, "_rd_en"}, buf_rd_en, 0);
        chk({nm, "_addr"}, buf_addr, 0);
        chk({nm, "_use_select"}, use_select, 0);
        chk({nm, "_use_read"}, use_read, 0);
        chk({nm, "_blk_cnt"}, blk_cnt, 0);
        chk({nm, "_ovf"}, ovf_err, 0);
        chk({nm, "_release"}, bank_release, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, rel0;

        tbl[0] = '{16'd0,   16'd0,   1'b0, 12'd0,   1'b0};
        tbl[1] = '{16'd0,   16'd1,   1'b0, 12'd1,   1'b0};
        tbl[2] = '{16'd1,   16'd0,   1'b0, 12'd8,   1'b0};
        tbl[3] = '{16'd1,   16'd1,   1'b1, 12'd9,   1'b0};
        tbl[4] = '{16'd300, 16'd5,   1'b0, 12'd709, 1'b1};
        tbl[5] = '{16'd255, 16'd255, 1'b0, 12'd239, 1'b1};
        tbl[6] = '{16'd0,   16'd15,  1'b0, 12'd15,  1'b1};
        tbl[7] = '{16'd1,   16'd0,   1'b1, 12'd16,  1'b1};

        reset = 1'b1; req_valid = 1'b0; loc_x = '0; loc_y = '0;
        new_block = 1'b0; read_finish = 1'b0; row_stride = 16'd8;
        fifo_amfull = 1'b0; bank_fill_done = 2'b00;
        #2;
        check_zero_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        idle_cycles(3, "idle_no_fill");

        // Block A: bank 0, stride 8.
        fill(2'b01);
        for (int i = 0; i < 4; i++) begin
            new_block = (i == 0);
            send(tbl[i].x, tbl[i].y, tbl[i].fin, tbl[i].addr, tbl[i].sel);
        end
        expect_release(2'b01, 16'd1, 1'b1);

        // Block B: bank 1 not yet filled, request must wait; stride 16 wraps.
        row_stride = 16'd16;
        present(tbl[4].x, tbl[4].y, tbl[4].fin, tbl[4].addr, tbl[4].sel);
        idle_cycles(4, "idle_bank1_empty");
        fill(2'b10);
        wait_accept();
        for (int i = 5; i < 8; i++) send(tbl[i].x, tbl[i].y, tbl[i].fin, tbl[i].addr, tbl[i].sel);
        expect_release(2'b10, 16'd2, 1'b0);

        // Block C: FIFO almost-full stall with a held request.
        row_stride = 16'd8;
        fill(2'b01);
        send(16'd2, 16'd3, 1'b0, 12'd19, 1'b0);
        send(16'd2, 16'd4, 1'b0, 12'd20, 1'b0);
        present(16'd3, 16'd0, 1'b0, 12'd24, 1'b0);
        fifo_amfull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ready", ready, 0);
            chk("stall_rd_en", buf_rd_en, 0);
        end
        @(posedge clk); #1;
        fifo_amfull = 1'b0;
        wait_accept();
        send(16'd3, 16'd1, 1'b1, 12'd25, 1'b0);
        expect_release(2'b01, 16'd3, 1'b1);
        chk("use_read_total", ur_cnt, acc_cnt);

        // Block D: bank 1; refill of full bank 0 raises overflow.
        fill(2'b10);
        fill(2'b01);
        chk("ovf_first_fill", ovf_err, 0);
        fill(2'b01);
        chk("ovf_set", ovf_err, 1);
        send(16'd0, 16'd2, 1'b0, 12'd2, 1'b1);
        send(16'd5, 16'd5, 1'b1, 12'd45, 1'b1);
        expect_release(2'b10, 16'd4, 1'b0);

        // Block E: bank 0 refilled in the same cycle it is released.
        send(16'd1, 16'd2, 1'b1, 12'd10, 1'b0);
        @(posedge clk); #1;
        bank_fill_done = 2'b01;
        @(negedge clk);
        chk("release_coincident", bank_release, 2'b01);
        @(posedge clk); #1;
        bank_fill_done = 2'b00;
        chk("blk_cnt_e", blk_cnt, 5);
        chk("use_select_e", use_select, 1);
        idle_cycles(3, "idle_bank1_after_e");

        // Block F: bank 1, then bank 0 must still be full.
        fill(2'b10);
        send(16'd7, 16'd7, 1'b1, 12'd63, 1'b1);
        expect_release(2'b10, 16'd6, 1'b0);
        chk("ovf_sticky", ovf_err, 1);

        // Block G: starts without a new fill, then reset lands in DRAIN.
        t0 = cyc;
        send(16'd0, 16'd0, 1'b1, 12'd0, 1'b0);
        chk("immediate_start", last_acc_cyc - t0, 1);
        rel0 = rel_cnt;
        #1 reset = 1'b1;
        #1;
        check_zero_outputs("reset_drain");
        pend.delete();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        chk("no_release_on_reset", rel_cnt, rel0);

        // Block H: after reset, waits for a fresh fill of bank 0.
        present(16'd2, 16'd1, 1'b1, 12'd17, 1'b0);
        idle_cycles(5, "idle_after_reset");
        fill(2'b01);
        wait_accept();
        expect_release(2'b01, 16'd1, 1'b1);

        chk("sb_drained", sb.size(), 0);
        chk("pend_drained", pend.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
